// File: rtl/mc_core.sv
// mc_core: multi-cycle core for the 8-opcode ISA with a req/ack data bus and a one-cycle-latency instruction ROM.
// Define MC_BUS_TIMEOUT_EN to abandon data-bus accesses after BUS_TIMEOUT cycles and raise a sticky bus_err.
module mc_core #(
  parameter int unsigned DBITS               = 32,
  parameter logic [31:0] START_PC            = 32'h40,
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned IMEM_ADDR_BIT_WIDTH = 11,
  parameter int unsigned BUS_TIMEOUT         = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [IMEM_ADDR_BIT_WIDTH-1:0] imem_addr,
  input  logic [31:0]                    imem_rdata,
  output logic                           dbus_req,
  output logic                           dbus_we,
  output logic [DBITS-1:0]               dbus_addr,
  output logic [DBITS-1:0]               dbus_wdata,
  input  logic [DBITS-1:0]               dbus_rdata,
  input  logic                           dbus_ack,
  output logic [DBITS-1:0]               pc_out,
  output logic                           instr_done,
  output logic                           bus_err
);
  localparam int unsigned numRegs = 1 << REG_INDEX_BIT_WIDTH;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [3:0] OP_ALUR  = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b1000;
  localparam logic [3:0] OP_CMPR  = 4'b0010;
  localparam logic [3:0] OP_CMPI  = 4'b1010;
  localparam logic [3:0] OP_BCOND = 4'b0110;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_LW    = 4'b1001;
  localparam logic [3:0] OP_JAL   = 4'b1011;

  logic [2:0]       state, stateNext;
  logic [DBITS-1:0] pc, pcNew, wbVal;
  logic [31:0]      ir;
  logic             wbEn;
  logic [DBITS-1:0] regFile [numRegs];

  logic [3:0]                     op1, op2;
  logic [REG_INDEX_BIT_WIDTH-1:0] rdIdx, rs1Idx, rs2Idx;
  logic [DBITS-1:0]               simm, simmShl, srcA, srcRs2, srcRd, pcPlus4;
  logic [DBITS-1:0]               execVal, execPc;
  logic                           execWe, isMemOp, timeoutHit;

  assign op1     = ir[31:28];
  assign op2     = ir[27:24];
  assign rdIdx   = REG_INDEX_BIT_WIDTH'(ir[23:20]);
  assign rs1Idx  = REG_INDEX_BIT_WIDTH'(ir[19:16]);
  assign rs2Idx  = REG_INDEX_BIT_WIDTH'(ir[15:12]);
  assign simm    = DBITS'($signed(ir[15:0]));
  assign simmShl = simm << 2;
  assign srcA    = regFile[rs1Idx];
  assign srcRs2  = regFile[rs2Idx];
  assign srcRd   = regFile[rdIdx];
  assign pcPlus4 = pc + DBITS'(4);
  assign isMemOp = (op1 == OP_LW) || (op1 == OP_SW);

  assign imem_addr = pc[IMEM_ADDR_BIT_WIDTH+1:2];
  assign pc_out    = pc;

  function automatic logic [DBITS-1:0] aluOp(input logic [3:0] fn, input logic [DBITS-1:0] x, input logic [DBITS-1:0] y);
    case (fn)
      4'h0:    aluOp = x + y;
      4'h1:    aluOp = x - y;
      4'h4:    aluOp = x & y;
      4'h5:    aluOp = x | y;
      4'h6:    aluOp = x ^ y;
      4'hC:    aluOp = ~(x & y);
      4'hD:    aluOp = ~(x | y);
      4'hE:    aluOp = ~(x ^ y);
      default: aluOp = '0;
    endcase
  endfunction

  // op2[3] inverts the base condition; code 4 (and its inverse) is undefined and always false
  function automatic logic condOp(input logic [3:0] fn, input logic [DBITS-1:0] x, input logic [DBITS-1:0] y);
    logic base;
    case (fn[2:0])
      3'd1:    base = (x == y);
      3'd2:    base = ($signed(x) < $signed(y));
      3'd3:    base = ($signed(x) <= $signed(y));
      3'd5:    base = (x == '0);
      3'd6:    base = x[DBITS-1];
      3'd7:    base = x[DBITS-1] || (x == '0);
      default: base = 1'b0;
    endcase
    condOp = (fn[2:0] == 3'd4) ? 1'b0 : (base ^ fn[3]);
  endfunction

  // Execute-stage result: writeback value (or bus address for LW/SW) and the successor PC
  always_comb begin
    execVal = '0;
    execPc  = pcPlus4;
    execWe  = 1'b0;
    case (op1)
      OP_ALUR: begin execVal = aluOp(op2, srcA, srcRs2); execWe = 1'b1; end
      OP_ALUI: begin
        execVal = (op2 == 4'hB) ? DBITS'({ir[15:0], 16'h0}) : aluOp(op2, srcA, simm);
        execWe  = 1'b1;
      end
      OP_CMPR:  begin execVal = DBITS'(condOp(op2, srcA, srcRs2)); execWe = 1'b1; end
      OP_CMPI:  begin execVal = DBITS'(condOp(op2, srcA, simm)); execWe = 1'b1; end
      OP_BCOND: if (condOp(op2, srcA, srcRd)) execPc = pcPlus4 + simmShl;
      OP_LW:    begin execVal = srcA + simm; execWe = 1'b1; end
      OP_SW:    execVal = srcA + simm;
      OP_JAL:   begin execVal = pcPlus4; execPc = srcA + simmShl; execWe = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:   stateNext = DECODE;
      DECODE:  stateNext = EXEC;
      EXEC: begin
        if (op1 == OP_BCOND) stateNext = FETCH;
        else if (isMemOp)    stateNext = MEM;
        else                 stateNext = WB;
      end
      MEM: begin
        if (dbus_ack)        stateNext = (op1 == OP_LW) ? WB : FETCH;
        else if (timeoutHit) stateNext = FETCH;
      end
      WB:      stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= DBITS'(START_PC);
      ir         <= '0;
      pcNew      <= '0;
      wbVal      <= '0;
      wbEn       <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        DECODE: ir <= imem_rdata;
        EXEC: begin
          wbVal <= execVal;
          pcNew <= execPc;
          wbEn  <= execWe;
          if (op1 == OP_BCOND) begin
            pc         <= execPc;
            instr_done <= 1'b1;
          end
          if (isMemOp) begin
            dbus_req   <= 1'b1;
            dbus_we    <= (op1 == OP_SW);
            dbus_addr  <= execVal;
            dbus_wdata <= srcRd;
          end
        end
        MEM: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            wbVal    <= dbus_rdata;
            if (op1 == OP_SW) begin
              pc         <= pcNew;
              instr_done <= 1'b1;
            end
          end else if (timeoutHit) begin
            dbus_req   <= 1'b0;
            pc         <= pcNew;
            instr_done <= 1'b1;
          end
        end
        WB: begin
          pc         <= pcNew;
          instr_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register file has no reset; a reset landing on WB suppresses the write
  always_ff @(posedge clk) begin
    if (!reset && state == WB && wbEn) regFile[rdIdx] <= wbVal;
  end

`ifdef MC_BUS_TIMEOUT_EN
  localparam int unsigned toWidth = $clog2(BUS_TIMEOUT + 1);
  logic [toWidth-1:0] toCnt;

  assign timeoutHit = (toCnt == toWidth'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      toCnt   <= '0;
      bus_err <= 1'b0;
    end else if (state == MEM && !dbus_ack) begin
      if (timeoutHit) begin
        toCnt   <= '0;
        bus_err <= 1'b1;
      end else begin
        toCnt <= toCnt + 1'b1;
      end
    end else begin
      toCnt <= '0;
    end
  end
`else
  logic unusedOk;
  assign unusedOk   = ^BUS_TIMEOUT;
  assign timeoutHit = 1'b0;
  assign bus_err    = 1'b0;
`endif
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: random and directed instruction stream checked against an architectural model of mc_core.
`timescale 1ns/1ps
module tb_mc_core;
  localparam int unsigned TIMEOUT = 4;
  localparam logic [3:0] OP_ALUR  = 4'b0000;
  localparam logic [3:0] OP_ALUI  = 4'b1000;
  localparam logic [3:0] OP_CMPR  = 4'b0010;
  localparam logic [3:0] OP_CMPI  = 4'b1010;
  localparam logic [3:0] OP_BCOND = 4'b0110;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_LW    = 4'b1001;
  localparam logic [3:0] OP_JAL   = 4'b1011;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, pc_out;
  logic        instr_done, bus_err;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [31:0] mReg [16];
  logic [31:0] mPc;
  logic        mBusErr;
  logic [3:0]  opTab [10] = '{OP_ALUR, OP_ALUI, OP_CMPR, OP_CMPI, OP_BCOND,
                              OP_SW, OP_LW, OP_JAL, 4'b0111, 4'b1111};

  mc_core #(
    .DBITS(32), .START_PC(32'h40), .REG_INDEX_BIT_WIDTH(4),
    .IMEM_ADDR_BIT_WIDTH(11), .BUS_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .pc_out(pc_out), .instr_done(instr_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] o1, input logic [3:0] o2,
                                      input logic [3:0] rd, input logic [3:0] rs1, input logic [15:0] imm);
    return {o1, o2, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] mAlu(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h4: return x & y;
      4'h5: return x | y;
      4'h6: return x ^ y;
      4'hC: return ~(x & y);
      4'hD: return ~(x | y);
      4'hE: return ~(x ^ y);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit mCond(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int signed sx, sy;
    sx = x;
    sy = y;
    case (c)
      4'h1: return sx == sy;
      4'h2: return sx < sy;
      4'h3: return sx <= sy;
      4'h5: return sx == 0;
      4'h6: return sx < 0;
      4'h7: return sx <= 0;
      4'h8: return 1'b1;
      4'h9: return sx != sy;
      4'hA: return sx >= sy;
      4'hB: return sx > sy;
      4'hD: return sx != 0;
      4'hE: return sx >= 0;
      4'hF: return sx > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkResetState();
    checkVal("rst_pc", pc_out, 32'h40);
    checkVal("rst_imem_addr", 32'(imem_addr), 32'd16);
    checkVal("rst_req", 32'(dbus_req), 32'd0);
    checkVal("rst_we", 32'(dbus_we), 32'd0);
    checkVal("rst_done", 32'(instr_done), 32'd0);
    checkVal("rst_bus_err", 32'(bus_err), 32'd0);
    checkVal("rst_addr", dbus_addr, 32'd0);
    checkVal("rst_wdata", dbus_wdata, 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    dbus_ack = 1'b0;
    @(posedge clk); #1;
    checkResetState();
    reset = 1'b0;
    mPc = 32'h40;
    mBusErr = 1'b0;
  endtask

  // Runs one instruction from FETCH to retirement; waitCyc < 0 means the bus never acks
  task automatic runInstr(input logic [31:0] ins, input int waitCyc, input logic [31:0] rdata, input bit noise);
    logic [3:0]  o1, o2;
    int          rd, rs1, rs2, cyc, reqCyc, expLat, expReq;
    logic [31:0] a, simm, res, nextPc, addr, wdata;
    bit          wr, isMem, isSt, done;
    o1 = ins[31:28]; o2 = ins[27:24];
    rd = int'(ins[23:20]); rs1 = int'(ins[19:16]); rs2 = int'(ins[15:12]);
    simm = 32'($signed(ins[15:0]));
    a = mReg[rs1]; res = 32'h0; nextPc = mPc + 32'd4;
    addr = 32'h0; wdata = 32'h0; wr = 0; isMem = 0; isSt = 0; expLat = 4;
    case (o1)
      OP_ALUR:  begin wr = 1; res = mAlu(o2, a, mReg[rs2]); end
      OP_ALUI:  begin wr = 1; res = (o2 == 4'hB) ? {ins[15:0], 16'h0} : mAlu(o2, a, simm); end
      OP_CMPR:  begin wr = 1; res = {31'b0, mCond(o2, a, mReg[rs2])}; end
      OP_CMPI:  begin wr = 1; res = {31'b0, mCond(o2, a, simm)}; end
      OP_BCOND: begin expLat = 3; if (mCond(o2, a, mReg[rd])) nextPc = mPc + 32'd4 + (simm << 2); end
      OP_LW:    begin wr = 1; isMem = 1; addr = a + simm; res = rdata; expLat = 5; end
      OP_SW:    begin isMem = 1; isSt = 1; addr = a + simm; wdata = mReg[rd]; end
      OP_JAL:   begin wr = 1; res = mPc + 32'd4; nextPc = a + (simm << 2); end
      default:  ;
    endcase
    expReq = waitCyc + 1;
    if (isMem) begin
      if (waitCyc < 0) begin wr = 0; expReq = TIMEOUT; expLat = 3 + TIMEOUT; end
      else expLat += waitCyc;
    end
    checkVal("fetch_pc", pc_out, mPc);
    checkVal("imem_addr", 32'(imem_addr), 32'(mPc[12:2]));
    imem_rdata = ins;
    cyc = 0; reqCyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      dbus_ack = 1'b0;
      if (instr_done) done = 1;
      else if (dbus_req) begin
        if (reqCyc == 0) begin
          checkVal("bus_addr", dbus_addr, addr);
          checkVal("bus_we", 32'(dbus_we), 32'(isSt));
          if (isSt) checkVal("bus_wdata", dbus_wdata, wdata);
        end
        reqCyc++;
        if (reqCyc == waitCyc + 1) begin dbus_ack = 1'b1; dbus_rdata = rdata; end
      end else if (noise) dbus_ack = 1'($urandom_range(0, 1));
    end
    dbus_ack = 1'b0;
    checkVal("retired", 32'(done), 32'd1);
    checkVal("latency", cyc, expLat);
    checkVal("next_pc", pc_out, nextPc);
    if (isMem) begin
      checkVal("req_cycles", reqCyc, expReq);
      checkVal("req_drop", 32'(dbus_req), 32'd0);
      if (waitCyc < 0) mBusErr = 1'b1;
    end
    checkVal("bus_err", 32'(bus_err), 32'(mBusErr));
    if (wr) mReg[rd] = res;
    mPc = nextPc;
  endtask

  // Every register's value leaves the core as store data
  task automatic storeAll();
    for (int r = 0; r < 16; r++)
      runInstr(enc(OP_SW, 4'h0, 4'(r), 4'($urandom_range(0, 15)), 16'($urandom)),
               $urandom_range(0, 2), 32'h0, 1);
  endtask

  // Reset while a memory op is stalled in MEM, or (inWb) while an acked LW sits in WB
  task automatic abortMem(input logic [31:0] ins, input bit inWb);
    int cyc;
    bit ready;
    cyc = 0; ready = 0;
    imem_rdata = ins;
    while (!ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (dbus_ack) begin dbus_ack = 1'b0; ready = 1; end
      else if (dbus_req) begin
        if (inWb) begin dbus_ack = 1'b1; dbus_rdata = $urandom; end
        else ready = 1;
      end
    end
    checkVal("abort_reached", 32'(ready), 32'd1);
    if (!inWb) begin @(posedge clk); #1; end
    doReset();
  endtask

  initial begin
    reset = 1'b1; imem_rdata = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    reset = 1'b0; mPc = 32'h40; mBusErr = 1'b0;

    runInstr(enc(OP_ALUI, 4'hB, 4'd1, 4'd0, 16'h0), 0, 32'h0, 0);
    runInstr(enc(OP_ALUI, 4'h0, 4'd1, 4'd1, 16'd5), 0, 32'h0, 0);
    for (int r = 0; r < 16; r++) begin
      runInstr(enc(OP_ALUI, 4'hB, 4'(r), 4'd0, 16'($urandom)), 0, 32'h0, 1);
      runInstr(enc(OP_ALUI, 4'h0, 4'(r), 4'(r), 16'($urandom)), 0, 32'h0, 1);
    end
    runInstr(enc(OP_ALUI, 4'hB, 4'd1, 4'd0, 16'h0), 0, 32'h0, 0);
    runInstr(enc(OP_ALUI, 4'h0, 4'd1, 4'd1, 16'd5), 0, 32'h0, 0);
    checkVal("r1_addi", mReg[1], 32'd5);
    for (int r = 2; r < 4; r++) begin
      runInstr(enc(OP_ALUI, 4'hB, 4'(r), 4'd0, 16'h0), 0, 32'h0, 0);
      runInstr(enc(OP_ALUI, 4'h0, 4'(r), 4'(r), 16'd7), 0, 32'h0, 0);
    end
    runInstr(enc(OP_ALUI, 4'hB, 4'd5, 4'd0, 16'hF000), 0, 32'h0, 0);
    runInstr(enc(OP_ALUI, 4'h0, 4'd5, 4'd5, 16'h0004), 0, 32'h0, 0);
    runInstr(enc(OP_ALUI, 4'hB, 4'd7, 4'd0, 16'h0), 0, 32'h0, 0);
    runInstr(enc(OP_ALUI, 4'h0, 4'd7, 4'd7, 16'h0020), 0, 32'h0, 0);
    storeAll();

    doReset();
    runInstr(enc(4'b0111, 4'h0, 4'd9, 4'd9, 16'h0), 0, 32'h0, 0);
    runInstr(enc(4'b1111, 4'h0, 4'd9, 4'd9, 16'h0), 0, 32'h0, 0);
    runInstr(enc(OP_BCOND, 4'h1, 4'd3, 4'd2, 16'hFFFE), 0, 32'h0, 0);
    checkVal("bcond_taken", pc_out, 32'h44);
    runInstr(enc(OP_ALUI, 4'h0, 4'd3, 4'd3, 16'd1), 0, 32'h0, 0);
    runInstr(enc(OP_BCOND, 4'h1, 4'd3, 4'd2, 16'hFFFE), 0, 32'h0, 0);
    checkVal("bcond_not_taken", pc_out, 32'h4C);
    runInstr(enc(OP_LW, 4'h0, 4'd4, 4'd5, 16'h0010), 3, 32'hDEADBEEF, 0);
    runInstr(enc(OP_JAL, 4'h0, 4'd6, 4'd7, 16'h0), 0, 32'h0, 0);
    checkVal("jal_target", pc_out, 32'h20);
    checkVal("jal_link", mReg[6], 32'h54);
    runInstr(enc(OP_ALUI, 4'hB, 4'd8, 4'd0, 16'h1234), 0, 32'h0, 0);
    storeAll();

    for (int i = 0; i < 200; i++)
      runInstr(enc(opTab[$urandom_range(0, 9)], 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)),
               $urandom_range(0, 3), $urandom, 1);
    storeAll();

    runInstr(enc(OP_ALUI, 4'h0, 4'd10, 4'd10, 16'd3), 0, 32'h0, 0);
    abortMem(enc(OP_SW, 4'h0, 4'd10, 4'd0, 16'h0), 0);
    runInstr(enc(OP_ALUI, 4'h0, 4'd11, 4'd11, 16'd9), 0, 32'h0, 0);
    abortMem(enc(OP_LW, 4'h0, 4'd11, 4'd0, 16'h0), 1);
    storeAll();

`ifdef MC_BUS_TIMEOUT_EN
    runInstr(enc(OP_LW, 4'h0, 4'd12, 4'd0, 16'h0100), -1, 32'h0, 0);
    checkVal("timeout_bus_err", 32'(bus_err), 32'd1);
    runInstr(enc(OP_ALUR, 4'h0, 4'd13, 4'd12, 16'h0), 0, 32'h0, 1);
    runInstr(enc(OP_SW, 4'h0, 4'd12, 4'd1, 16'h0), 1, 32'h0, 1);
    doReset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle Project2 core. Executes the same 8-opcode ISA through a five-state FSM instead of one cycle per instruction.
- Data memory and memory-mapped I/O are reached through a req/ack bus, so devices may stall for any number of cycles.
- Instruction memory is a synchronous ROM with one-cycle read latency.
- Sits between the board top level (PLL, I/O) and external InstMemory/DataMemory-style blocks.

Parameters:
- DBITS, 32, datapath and register width (>=16).
- START_PC, 32'h40, PC loaded on reset.
- REG_INDEX_BIT_WIDTH, 4, register file has 2**N entries.
- IMEM_ADDR_BIT_WIDTH, 11, word address width to instruction ROM.
- BUS_TIMEOUT, 255, cycles to wait for dbus_ack (used only with MC_BUS_TIMEOUT_EN).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- imem_addr  out  IMEM_ADDR_BIT_WIDTH  word address, equals pc[IMEM_ADDR_BIT_WIDTH+1:2].
- imem_rdata  in  32  instruction word, valid one cycle after imem_addr.
- dbus_req  out  1  data bus request, held until ack.
- dbus_we  out  1  1 = store, 0 = load; stable while req.
- dbus_addr  out  DBITS  byte address; stable while req.
- dbus_wdata  out  DBITS  store data; stable while req.
- dbus_rdata  in  DBITS  load data, sampled on the ack cycle.
- dbus_ack  in  1  one-cycle completion pulse.
- pc_out  out  DBITS  current PC, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- bus_err  out  1  sticky timeout flag (feature only; otherwise tied 0).

Behaviour:
- Encoding: op1[31:28], op2[27:24], rd[23:20], rs1[19:16], rs2[15:12], imm16[15:0]. simm is imm16 sign-extended to DBITS.
- op1 values: ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001, JAL 1011.
- ALU op2: ADD 0, SUB 1, AND 4, OR 5, XOR 6, NAND C, NOR D, XNOR E, MVHI B (ALUI only: rd = imm16<<16, truncated to DBITS).
- Condition op2: F 0, EQ 1, LT 2, LTE 3, EQZ 5, LTZ 6, LTEZ 7; op2[3]=1 inverts the condition.
  - Comparisons are signed.
  - "Z" forms compare rs1 with 0.
  - op2 codes not listed in either table produce a result of 0 / false.
- Per opcode:
  - ALUR: rd = rs1 op rs2.
  - ALUI: rd = rs1 op simm.
  - CMPR/CMPI: rd = cond ? 1 : 0.
  - BCOND: compares rs1 with rd (the second source field); if taken, pc = pc+4+(simm<<2).
  - LW: rd = mem[rs1+simm].
  - SW: mem[rs1+simm] = rd.
  - JAL: rd = pc+4, pc = rs1+(simm<<2).
  - Undefined op1 executes as a NOP (pc+4, no writes).
- Arithmetic wraps modulo 2**DBITS.
- Register 0 is a normal register. The register file is not cleared on reset.
- FSM states:
  - FETCH: drive imem_addr. Go to DECODE.
  - DECODE: latch imem_rdata, read operands. Go to EXEC.
  - EXEC: compute ALU/condition/address.
    - BCOND: update pc, pulse instr_done, go to FETCH.
    - LW/SW: go to MEM.
    - Otherwise: go to WB.
  - MEM: assert dbus_req.
    - On the ack cycle: deassert req next cycle. LW goes to WB. SW updates pc, pulses instr_done, goes to FETCH.
  - WB: write rd, update pc, pulse instr_done. Go to FETCH.
- Latency with zero-wait ack:
  - ALU/CMP/JAL: 4 cycles.
  - BCOND: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each extra wait cycle adds 1.
- The ack cycle itself counts as the single MEM cycle.
- dbus_ack while not in MEM is ignored.
- Reset, including mid-MEM: next edge gives state=FETCH, pc=START_PC, dbus_req=0, dbus_we=0, instr_done=0, bus_err=0. dbus_addr/dbus_wdata = 0. No register write for the aborted instruction.
- PC wraps modulo 2**DBITS.
- imem_addr drops upper PC bits.

Optional Feature:
- Macro: MC_BUS_TIMEOUT_EN.
- Defined:
  - A counter runs in MEM.
  - If BUS_TIMEOUT cycles pass without ack: drop req, set sticky bus_err (cleared only by reset), skip the LW write, pc += 4, retire, return to FETCH.
- Undefined: MEM waits indefinitely; bus_err is constant 0.

Test Plan:
- Reset → pc_out=32'h40 and imem_addr=16; after reset is released, first instr_done after exactly 4 cycles for ADDI r1,r1,5 (r1 starts at 0) → r1=5.
- BCOND EQ r2==r3 (both 7), simm=-2, at pc 0x48 → 3 cycles later pc_out=0x44. With r3=8 → pc_out=0x4C.
- LW r4,0x10(r5), r5=0xF0000004, ack after 3 wait cycles returning 0xDEADBEEF → dbus_addr=0xF0000014, dbus_we=0, req held 4 cycles, r4=0xDEADBEEF, total 8 cycles.
- JAL r6,0(r7), r7=0x20, at pc 0x50 → r6=0x54, pc_out=0x20. MVHI r8,0x1234 → r8=0x12340000.
- Reset asserted during MEM of SW → req low next cycle, no pc advance, pc_out=0x40.
- With MC_BUS_TIMEOUT_EN and BUS_TIMEOUT=4, never ack → req drops after 4 cycles, bus_err=1, pc advances by 4, bus_err stays 1 until reset.
